fir_tap_mac: RTL
================

Name: fir_tap_mac

Overview:
Downstream consumer of the FIR serial-in/parallel-out tap buffer. On the buffer's window-ready strobe (flags), it snapshots the three parallel tap words (low, hi, select) and multiplies each by a programmable signed coefficient. It accumulates the three products over three cycles, then rounds, shifts and saturates the sum to a 32-bit filter output. The output is presented with a valid/ready handshake to the next stage.

Parameters:
COEF_W, 16, signed coefficient width.
SHIFT, 8, arithmetic right shift applied to the accumulator before output (0..31).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
enable  in  1  global advance; when low, all state, counters and outputs hold.
flags  in  1  window-ready strobe from the tap buffer.
low_data_in  in  32  tap 0 sample, signed.
hi_data_in  in  32  tap 1 sample, signed.
select_in  in  32  tap 2 sample, signed.
coef_we  in  1  coefficient write strobe.
coef_addr  in  2  coefficient index 0..2; value 3 is ignored.
coef_data  in  COEF_W  signed coefficient value.
result  out  32  signed filter output.
result_valid  out  1  result holds a valid sample.
result_ready  in  1  downstream accepts the result.
busy  out  1  high in every state except IDLE.
overrun  out  1  sticky; a window was dropped.

Behaviour:
- Reset (reset=0, async): state=IDLE; result=0; result_valid=0; busy=0; overrun=0; accumulator=0; tap index=0; coefficients=0.
- FSM states: IDLE, MAC, ROUND, OUT. The FSM advances only on clock edges where enable=1.
- IDLE:
  - Condition: flags=1.
  - Action: latch low, hi and select into window regs w0, w1, w2; clear acc; set tap index=0; go to MAC.
- MAC:
  - Each enabled cycle: acc += w[idx]*c[idx] (signed 32xCOEF_W product, sign-extended; acc width 32+COEF_W+2), then idx++.
  - After idx=2 is accumulated, go to ROUND.
- ROUND:
  - Compute t = (acc + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT.
  - Saturate t to [0x80000000, 0x7FFFFFFF] and register it into result.
  - Set result_valid=1; go to OUT.
- OUT:
  - result and result_valid hold until result_valid & result_ready on an enabled edge.
  - On handshake, result_valid drops the next cycle and the FSM returns to IDLE.
  - If flags=1 on the same edge as the handshake, the new window is captured directly (OUT->MAC); result_valid drops.
- Latency: capture edge E. With enable held high, result_valid is visible after edge E+4 (3 MAC edges + 1 ROUND edge).
- Throughput: one window per 5 cycles minimum.
- Overrun:
  - flags=1 with enable=1 in MAC or ROUND, or in OUT without handshake, sets overrun.
  - The window is dropped; in-flight computation is unaffected.
  - overrun is cleared only by reset.
- Coefficients:
  - Written on an enabled edge with coef_we=1 and coef_addr<3, only while state=IDLE.
  - Writes in other states or with coef_addr=3 are ignored, with no flag.
  - A write on the same edge as a flags capture takes effect for that window.
- enable=0:
  - flags and coef_we are ignored, and overrun does not set.
  - result_valid stays asserted if already high, but no handshake completes.
- Reset asserted mid-operation aborts immediately to the reset values; no partial result is emitted.

Test Plan:
- Basic MAC:
  - Stimulus: SHIFT=8; write c0=256, c1=512, c2=768; pulse flags with low=10, hi=20, select=30; hold result_ready=1.
  - Response: result=140; result_valid high exactly one cycle, 4 edges after capture.
- Rounding and sign:
  - Stimulus: c0=128, c1=c2=0; window low=1 (others 0), then a second window low=-1.
  - Response: results 1 then 0; busy returns to 0 between windows.
- Saturation:
  - Stimulus: c0..c2=0x7FFF; window of three 0x7FFFFFFF words.
  - Response: result=0x7FFFFFFF.
  - Stimulus: c0..c2=0x8000; same window.
  - Response: result=0x80000000.
- Backpressure and overrun:
  - Stimulus: result_ready=0 for 10 cycles after valid; pulse flags in OUT.
  - Response: result stable, overrun=1, no second result.
  - Stimulus: then result_ready=1 together with flags.
  - Response: handshake completes and the new window is captured (OUT->MAC).
- Enable stall:
  - Stimulus: drop enable for 3 cycles during MAC.
  - Response: latency grows by exactly 3 cycles; result unchanged (140 for basic vector).
  - Stimulus: coef_we during MAC.
  - Response: write ignored.
- Async reset mid-MAC:
  - Stimulus: assert reset between edges during MAC.
  - Response: all outputs go to 0 without waiting for a clock; coefficients read back as 0 (next window yields result=0).

Source files
------------

// File: rtl/fir_tap_mac.sv
// Three-tap multiply-accumulate stage fed by the FIR tap buffer.
// Captures a window, runs three MAC cycles, rounds/saturates, then hands off via valid/ready.
module fir_tap_mac #(
    parameter int COEF_W = 16,
    parameter int SHIFT  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              flags,
    input  logic [31:0]       low_data_in,
    input  logic [31:0]       hi_data_in,
    input  logic [31:0]       select_in,
    input  logic              coef_we,
    input  logic [1:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic [31:0]       result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy,
    output logic              overrun
);
    // state | meaning
    // IDLE  | waiting for a window; coefficient writes accepted
    // MAC   | accumulating tap idx (0..2), one per enabled cycle
    // ROUND | round, shift and saturate accumulator into result
    // OUT   | result_valid held until handshake

    localparam int PROD_W = 32 + COEF_W;
    localparam int ACC_W  = 32 + COEF_W + 2;
    localparam logic signed [ACC_W-1:0] RND =
        (SHIFT == 0) ? '0 : (ACC_W'(1) << ((SHIFT == 0) ? 0 : SHIFT - 1));
    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-31){1'b0}}, {31{1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-31){1'b1}}, {31{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND, S_OUT} state_t;
    state_t state_q, state_d;

    logic signed [31:0]       w0_q, w1_q, w2_q, w0_d, w1_d, w2_d;
    logic signed [COEF_W-1:0] c0_q, c1_q, c2_q, c0_d, c1_d, c2_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [1:0]               idx_q, idx_d;
    logic [31:0]              result_q, result_d;
    logic                     valid_q, valid_d;
    logic                     overrun_q, overrun_d;

    logic                     handshake, capture;
    logic signed [31:0]       tap_sel;
    logic signed [COEF_W-1:0] coef_sel;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  rsum, shifted;

    assign handshake = enable & valid_q & result_ready;
    assign capture   = enable & flags &
                       ((state_q == S_IDLE) | ((state_q == S_OUT) & handshake));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (enable) begin
            case (state_q)
                S_IDLE:  if (flags) state_d = S_MAC;
                S_MAC:   if (idx_q == 2'd2) state_d = S_ROUND;
                S_ROUND: state_d = S_OUT;
                S_OUT:   if (handshake) state_d = flags ? S_MAC : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q != S_IDLE);
    end

    always_comb begin
        case (idx_q)
            2'd0:    begin tap_sel = w0_q; coef_sel = c0_q; end
            2'd1:    begin tap_sel = w1_q; coef_sel = c1_q; end
            default: begin tap_sel = w2_q; coef_sel = c2_q; end
        endcase
        prod    = tap_sel * coef_sel;
        rsum    = acc_q + RND;
        shifted = rsum >>> SHIFT;
    end

    always_comb begin
        w0_d      = w0_q;
        w1_d      = w1_q;
        w2_d      = w2_q;
        c0_d      = c0_q;
        c1_d      = c1_q;
        c2_d      = c2_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        result_d  = result_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (enable) begin
            case (state_q)
                S_MAC: begin
                    acc_d = acc_q + {{2{prod[PROD_W-1]}}, prod};
                    idx_d = idx_q + 2'd1;
                    if (flags) overrun_d = 1'b1;
                end
                S_ROUND: begin
                    if (shifted > MAXV)      result_d = MAXV[31:0];
                    else if (shifted < MINV) result_d = MINV[31:0];
                    else                     result_d = shifted[31:0];
                    valid_d = 1'b1;
                    if (flags) overrun_d = 1'b1;
                end
                S_OUT: begin
                    if (handshake)  valid_d   = 1'b0;
                    else if (flags) overrun_d = 1'b1;
                end
                default: ;
            endcase
            // Same-edge write and capture: the new coefficient is in place before the first MAC edge.
            if (state_q == S_IDLE && coef_we) begin
                case (coef_addr)
                    2'd0:    c0_d = coef_data;
                    2'd1:    c1_d = coef_data;
                    2'd2:    c2_d = coef_data;
                    default: ;
                endcase
            end
        end
        if (capture) begin
            w0_d  = low_data_in;
            w1_d  = hi_data_in;
            w2_d  = select_in;
            acc_d = '0;
            idx_d = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w0_q      <= '0;
            w1_q      <= '0;
            w2_q      <= '0;
            c0_q      <= '0;
            c1_q      <= '0;
            c2_q      <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            w0_q      <= w0_d;
            w1_q      <= w1_d;
            w2_q      <= w2_d;
            c0_q      <= c0_d;
            c1_q      <= c1_d;
            c2_q      <= c2_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign result       = result_q;
    assign result_valid = valid_q;
    assign overrun      = overrun_q;

endmodule
